mac_seq_driver: RTL and testbench

- Initiator/sequencer for the registered 4-lane MAC wrapper (mac_wrapper_b). It drives a0..a3/b0..b3/c and consumes the returned psum.
- Accepts a stream of packed 4-activation/4-weight groups and chains the wrapper output back as the next c. After num_groups groups it presents the final psum on a valid/ready result port.
- Sits between the L0/weight buffers and the MAC wrapper; one instance per MAC column.

---
 rtl/mac_seq_driver_pkg.sv | 18 +
 rtl/mac_seq_driver_if.sv | 25 ++
 rtl/mac_seq_driver_lane_unpack.sv | 18 +
 rtl/mac_wrapper_b.sv | 38 +++
 rtl/mac_seq_driver.sv | 104 ++++++++++
 tb/tb_mac_seq_driver.sv | 167 ++++++++++++++++
 6 files changed

// File: rtl/mac_seq_driver_pkg.sv
// Shared constants and state encoding for the MAC sequencer column driver.
package mac_seq_driver_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_RUN   = RUN,
    S_DRAIN = DRAIN,
    S_DONE  = DONE
  } state_t;

endpackage

// File: rtl/mac_seq_driver_if.sv
// Group input stream and result stream of the MAC sequencer as one bundle.
interface mac_seq_driver_if
  import mac_seq_driver_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_LANES*bw-1:0]  in_act;
  logic [NUM_LANES*bw-1:0]  in_wgt;
  logic                     res_valid;
  logic                     res_ready;
  logic [psum_bw-1:0]       res_data;

  modport master (
    output in_valid, in_act, in_wgt, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_act, in_wgt, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_seq_driver_lane_unpack.sv
// Slices packed activation/weight groups into lanes; lanes read zero unless a
// group is actually transferred, so the wrapper sees a neutral bubble.
module mac_lane_unpack
  import mac_seq_driver_pkg::*;
#(
  parameter int bw = 4
) (
  input  logic [NUM_LANES*bw-1:0] act,
  input  logic [NUM_LANES*bw-1:0] wgt,
  input  logic                    xfer,
  output logic [bw-1:0]           a [NUM_LANES],
  output logic [bw-1:0]           b [NUM_LANES]
);
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign a[gi] = xfer ? act[gi*bw +: bw] : '0;
    assign b[gi] = xfer ? wgt[gi*bw +: bw] : '0;
  end
endmodule

// File: rtl/mac_wrapper_b.sv
// Registered 4-lane MAC: inputs captured each edge, out = c + sum(a*b) from
// the captured values (combinational after the registers).
module mac_wrapper_b #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [bw-1:0]      a0, a1, a2, a3,
  input  logic [bw-1:0]      b0, b1, b2, b3,
  input  logic [psum_bw-1:0] c,
  output logic [psum_bw-1:0] out
);
  logic [bw-1:0]      a_q [4];
  logic [bw-1:0]      b_q [4];
  logic [psum_bw-1:0] c_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      c_q <= '0;
    end else begin
      a_q[0] <= a0; a_q[1] <= a1; a_q[2] <= a2; a_q[3] <= a3;
      b_q[0] <= b0; b_q[1] <= b1; b_q[2] <= b2; b_q[3] <= b3;
      c_q    <= c;
    end
  end

  always_comb begin
    out = c_q;
    for (int i = 0; i < 4; i++) begin
      out = out + psum_bw'(a_q[i]) * psum_bw'(b_q[i]);
    end
  end
endmodule

// File: rtl/mac_seq_driver.sv
// Column sequencer: streams activation/weight groups into the registered MAC
// wrapper, chaining its psum back as c, and returns the final psum.
module mac_seq_driver
  import mac_seq_driver_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int cnt_bw  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [cnt_bw-1:0]   num_groups,
  input  logic [psum_bw-1:0]  bias,
  mac_seq_driver_if.slave     stream,
  output logic [bw-1:0]       mac_a0, mac_a1, mac_a2, mac_a3,
  output logic [bw-1:0]       mac_b0, mac_b1, mac_b2, mac_b3,
  output logic [psum_bw-1:0]  mac_c,
  input  logic [psum_bw-1:0]  mac_out,
  output logic                busy
);
  state_t              state_reg, state_next;
  logic [psum_bw-1:0]  acc_q, acc_next;
  logic [cnt_bw-1:0]   cnt, cnt_next;
  logic                issued_q;
  logic                run_ready;
  logic                xfer;
  logic                res_valid_c;
  logic [psum_bw-1:0]  res_data_c;
  logic [bw-1:0]       lane_a [NUM_LANES];
  logic [bw-1:0]       lane_b [NUM_LANES];

  assign run_ready = (state_reg == S_RUN);
  assign xfer      = stream.in_valid && run_ready;

  mac_lane_unpack #(.bw(bw)) u_unpack (
    .act  (stream.in_act),
    .wgt  (stream.in_wgt),
    .xfer (xfer),
    .a    (lane_a),
    .b    (lane_b)
  );

  assign mac_a0 = lane_a[0]; assign mac_a1 = lane_a[1];
  assign mac_a2 = lane_a[2]; assign mac_a3 = lane_a[3];
  assign mac_b0 = lane_b[0]; assign mac_b1 = lane_b[1];
  assign mac_b2 = lane_b[2]; assign mac_b3 = lane_b[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      acc_q     <= '0;
      cnt       <= '0;
      issued_q  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_q     <= acc_next;
      cnt       <= cnt_next;
      issued_q  <= xfer;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_q;
    cnt_next    = cnt;
    mac_c       = '0;
    res_valid_c = 1'b0;
    res_data_c  = '0;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          cnt_next   = num_groups;
          acc_next   = bias;
          state_next = (num_groups == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Right after an issue the freshest psum is only on mac_out.
        mac_c    = issued_q ? mac_out : acc_q;
        acc_next = mac_c;
        if (xfer) begin
          cnt_next = cnt - cnt_bw'(1);
          if (cnt == cnt_bw'(1)) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        acc_next   = mac_out;
        state_next = S_DONE;
      end
      S_DONE: begin
        res_valid_c = 1'b1;
        res_data_c  = acc_q;
        if (stream.res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign stream.in_ready  = run_ready;
  assign stream.res_valid = res_valid_c;
  assign stream.res_data  = res_data_c;
  assign busy             = (state_reg != S_IDLE);
endmodule

// File: tb/tb_mac_seq_driver.sv
// Scoreboard bench for mac_seq_driver driving the registered MAC wrapper.
module tb_mac_seq_driver;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  num_groups;
  logic [15:0] bias;
  logic [3:0]  mac_a0, mac_a1, mac_a2, mac_a3;
  logic [3:0]  mac_b0, mac_b1, mac_b2, mac_b3;
  logic [15:0] mac_c, mac_out;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb [$];

  mac_seq_driver_if #(.bw(4), .psum_bw(16)) bus ();

  mac_seq_driver #(.bw(4), .psum_bw(16), .cnt_bw(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_groups(num_groups),
    .bias(bias), .stream(bus),
    .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2), .mac_a3(mac_a3),
    .mac_b0(mac_b0), .mac_b1(mac_b1), .mac_b2(mac_b2), .mac_b3(mac_b3),
    .mac_c(mac_c), .mac_out(mac_out), .busy(busy)
  );

  mac_wrapper_b #(.bw(4), .psum_bw(16)) u_mac (
    .clk(clk), .reset_n(reset_n),
    .a0(mac_a0), .a1(mac_a1), .a2(mac_a2), .a3(mac_a3),
    .b0(mac_b0), .b1(mac_b1), .b2(mac_b2), .b3(mac_b3),
    .c(mac_c), .out(mac_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [15:0] bias_v, input int n,
                         input logic [15:0] act_v, input logic [15:0] wgt_v,
                         input int gap, input int bp);
    logic [15:0] dot, running, held, exp_res;
    int waited;
    dot = 16'd0;
    for (int i = 0; i < 4; i++) dot = dot + 16'(act_v[i*4 +: 4]) * 16'(wgt_v[i*4 +: 4]);
    sb.push_back(16'(bias_v + 16'(n) * dot));
    running = bias_v;

    start = 1'b1; num_groups = 8'(n); bias = bias_v;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);

    for (int g = 0; g < n; g++) begin
      if (g > 0) begin
        for (int k = 0; k < gap; k++) begin
          bus.in_valid = 1'b0;
          #1;
          check("bubble_a0", mac_a0, 0);
          check("bubble_b3", mac_b3, 0);
          check("bubble_c", mac_c, running);
          step();
        end
      end
      bus.in_valid = 1'b1; bus.in_act = act_v; bus.in_wgt = wgt_v;
      #1;
      check("in_ready_run", bus.in_ready, 1);
      check("lane_a0", mac_a0, act_v[3:0]);
      check("lane_a3", mac_a3, act_v[15:12]);
      check("lane_b0", mac_b0, wgt_v[3:0]);
      check("chain_c", mac_c, running);
      running = running + dot;
      step();
    end

    // Keep offering data after the job: it must not be accepted.
    waited = 0;
    while (!bus.res_valid && waited < 10) begin
      check("in_ready_drain", bus.in_ready, 0);
      check("drain_a0", mac_a0, 0);
      step();
      waited++;
    end
    bus.in_valid = 1'b0;
    check("res_latency", waited, (n == 0) ? 0 : 1);
    check("in_ready_done", bus.in_ready, 0);
    if (!bus.res_valid) return;

    held = bus.res_data;
    for (int k = 0; k < bp; k++) begin
      bus.res_ready = 1'b0; start = 1'b1;
      step();
      check("bp_valid", bus.res_valid, 1);
      check("bp_data", bus.res_data, held);
    end
    start = 1'b0; bus.res_ready = 1'b1;
    #1;
    exp_res = sb.pop_front();
    check("res_data", bus.res_data, exp_res);
    step();
    bus.res_ready = 1'b0;
    check("res_valid_clear", bus.res_valid, 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; num_groups = '0; bias = '0;
    bus.in_valid = 1'b0; bus.in_act = '0; bus.in_wgt = '0; bus.res_ready = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_mac_c", mac_c, 0);
    check("rst_mac_a0", mac_a0, 0);
    reset_n = 1'b1;
    step();

    run_job(16'd5, 1, 16'h1234, 16'h1111, 0, 0);      // 15
    run_job(16'd0, 3, 16'h2222, 16'h3333, 0, 0);      // 72
    run_job(16'd0, 3, 16'h2222, 16'h3333, 2, 0);      // 72 with bubbles
    run_job(16'h1234, 0, 16'h0000, 16'h0000, 0, 0);   // bias only
    run_job(16'd7, 2, 16'hF1F1, 16'h2F2F, 1, 4);      // backpressure
    run_job(16'hFFF0, 2, 16'hFFFF, 16'hFFFF, 0, 0);   // psum wrap

    // Reset in the middle of a 3-group job.
    start = 1'b1; num_groups = 8'd3; bias = 16'd0;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_act = 16'h2222; bus.in_wgt = 16'h3333;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_mac_a0", mac_a0, 0);
    check("mid_rst_mac_c", mac_c, 0);
    bus.in_valid = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    check("post_rst_res_valid", bus.res_valid, 0);
    run_job(16'd1, 1, 16'h1111, 16'h1111, 0, 0);      // 5

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
